logic_unit_pipe: RTL
====================

# logic_unit_pipe

Parametrised, pipelined bitwise logic unit: the registered, multi-operation successor to the fixed-width combinational inverter in the Hack elementary-logic set. Each beat applies one of eight bitwise operations to two WIDTH-bit operands and returns the result with Hack-style zero/negative flags. Valid/ready handshakes on both sides, with a one-entry skid buffer, give full throughput under backpressure. Sits between operand sources (register file / decode) and downstream Hack ALU or writeback logic.

## Interface
- WIDTH, 16, operand/result width in bits; legal range 2..64.
- clk  in  1  rising-edge clock; the single clock for the block.
- rst_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- in_valid  in  1  operand beat present.
- in_ready  out  1  block can accept a beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B; ignored by NOT and PASS.
- op  in  3  operation select.
- out_valid  out  1  result beat present.
- out_ready  in  1  consumer accepts the beat this cycle.
- result  out  WIDTH  operation result.
- zr  out  1  result == 0.
- ng  out  1  result[WIDTH-1].

## Operation
- op encoding: 000 NOT a; 001 a AND b; 010 a OR b; 011 a XOR b; 100 NAND; 101 NOR; 110 XNOR; 111 PASS a.
- Input transfer on in_valid && in_ready at a clock edge. Output transfer on out_valid && out_ready.
- zr and ng are computed from the same value as result and registered with it. They are never recomputed from a later beat.
- Storage: main output register (M) drives result/zr/ng/out_valid, plus a one-entry skid register (S).
- The block is a 3-state FSM on {M valid, S valid}:
  - EMPTY: M and S invalid.
  - ONE: only M valid.
  - FULL: M and S valid.
- EMPTY + accept -> ONE.
- ONE + accept + out transfer -> ONE. M loads the new beat.
- ONE + accept, no out transfer -> FULL. The new beat goes to S.
- ONE + out transfer, no accept -> EMPTY.
- FULL + out transfer -> ONE. S moves to M. No accept is possible, because in_ready is 0.
- in_ready is registered. It is 1 in EMPTY and ONE, and 0 in FULL.
- Beats leave in acceptance order. No beat is dropped or duplicated.
- When out_valid is 0, result/zr/ng hold their last values. The consumer must ignore them.
- While out_valid is 1 and out_ready is 0, result/zr/ng/out_valid are held stable.

## Timing
- Latency: a beat accepted at edge k is visible on the outputs in the cycle after edge k, with out_valid = 1.
- Throughput: one beat per cycle while out_ready is held high.
- in_ready deasserts in the cycle after the edge that enters FULL. It reasserts in the cycle after the edge that leaves FULL.
- Reset applies on any edge with rst_n = 0, including mid-transfer. State -> EMPTY. Contents of M and S are discarded.
- Reset values: out_valid = 0, in_ready = 0, result = 0, zr = 0, ng = 0.
- in_ready first rises to 1 after the first edge with rst_n = 1.
- in_valid is ignored while rst_n = 0.
- WIDTH = 2 and WIDTH = 64 must elaborate and behave identically apart from width.

## Test plan
- Op sweep, WIDTH = 16, out_ready = 1: a = 16'h00FF, b = 16'h0F0F, op = 0..7. Results in order: FF00, 000F, 0FFF, 0FF0, FFF0, F000, F00F, 00FF. ng = 1 for FF00, FFF0, F000 and F00F only. Each result appears one cycle after acceptance.
- Zero flag: a = 16'hFFFF, op = NOT. Required: result = 0000, zr = 1, ng = 0. Then a = 16'h0000, op = NOT. Required: result = FFFF, zr = 0, ng = 1.
- Backpressure and skid:
  - Stream beats 1, 2, 3 with out_ready = 0.
  - Required: beat 1 is held in M and beat 2 goes to S. in_ready = 0 from the cycle after beat 2 is accepted, so beat 3 is stalled.
  - Raise out_ready. Required: outputs 1, 2, 3 in order, with no loss or duplication.
- Full throughput: 100 random beats with in_valid = 1 and out_ready = 1. Required: 100 outputs on consecutive cycles, each matching the reference model.
- Reset mid-operation: reach FULL, then assert rst_n = 0 for one edge. Required on the following cycle: out_valid = 0, in_ready = 0, result = 0. The cycle after that: in_ready = 1, and old beats never appear.
- Width corners: WIDTH = 2 and WIDTH = 64 builds. Required: all-ones with NOT gives zr = 1. PASS a = 1 << (WIDTH-1) gives ng = 1.

Source files
------------

// File: rtl/logic_unit_pipe.sv
// Pipelined bitwise logic unit with Hack-style zr/ng flags.
// The output register is backed by a one-entry skid register, so the block sustains one beat per cycle under backpressure.
module logic_unit_pipe #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zr,
   output logic             ng
);

   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_ONE   = 2'd1;
   localparam logic [1:0] ST_FULL  = 2'd2;

   logic [1:0]       r_state;
   logic [1:0]       w_state_d;
   logic             r_in_ready;
   logic [WIDTH-1:0] w_res;
   logic             w_zr;
   logic             w_ng;
   logic [WIDTH-1:0] r_m_res;
   logic             r_m_zr;
   logic             r_m_ng;
   logic [WIDTH-1:0] r_s_res;
   logic             r_s_zr;
   logic             r_s_ng;
   logic             w_acc;
   logic             w_out;
   logic             w_load_m_new;
   logic             w_load_m_skid;
   logic             w_load_s;

   always_comb begin
      w_res = '0;
      case (op)
         3'b000:  w_res = ~a;
         3'b001:  w_res = a & b;
         3'b010:  w_res = a | b;
         3'b011:  w_res = a ^ b;
         3'b100:  w_res = ~(a & b);
         3'b101:  w_res = ~(a | b);
         3'b110:  w_res = ~(a ^ b);
         default: w_res = a;
      endcase
   end

   // Flags travel with the beat so a stalled result never picks up a later beat's flags.
   assign w_zr = ~|w_res;
   assign w_ng = w_res[WIDTH-1];

   assign w_acc = in_valid && r_in_ready;
   assign w_out = out_valid && out_ready;

   always_comb begin
      w_state_d     = r_state;
      w_load_m_new  = 1'b0;
      w_load_m_skid = 1'b0;
      w_load_s      = 1'b0;
      case (r_state)
         ST_EMPTY: begin
            if (w_acc) begin
               w_state_d    = ST_ONE;
               w_load_m_new = 1'b1;
            end
         end
         ST_ONE: begin
            if (w_acc && w_out) begin
               w_load_m_new = 1'b1;
            end else if (w_acc) begin
               w_state_d = ST_FULL;
               w_load_s  = 1'b1;
            end else if (w_out) begin
               w_state_d = ST_EMPTY;
            end
         end
         ST_FULL: begin
            if (w_out) begin
               w_state_d     = ST_ONE;
               w_load_m_skid = 1'b1;
            end
         end
         default: w_state_d = ST_EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= ST_EMPTY;
         r_in_ready <= 1'b0;
         r_m_res    <= '0;
         r_m_zr     <= 1'b0;
         r_m_ng     <= 1'b0;
         r_s_res    <= '0;
         r_s_zr     <= 1'b0;
         r_s_ng     <= 1'b0;
      end else begin
         r_state    <= w_state_d;
         r_in_ready <= (w_state_d != ST_FULL);
         if (w_load_m_new) begin
            r_m_res <= w_res;
            r_m_zr  <= w_zr;
            r_m_ng  <= w_ng;
         end else if (w_load_m_skid) begin
            r_m_res <= r_s_res;
            r_m_zr  <= r_s_zr;
            r_m_ng  <= r_s_ng;
         end
         if (w_load_s) begin
            r_s_res <= w_res;
            r_s_zr  <= w_zr;
            r_s_ng  <= w_ng;
         end
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = (r_state != ST_EMPTY);
   assign result    = r_m_res;
   assign zr        = r_m_zr;
   assign ng        = r_m_ng;

endmodule
